// File: rtl/result_arbiter.sv
// result_arbiter: round-robin write-back arbiter for NUM_REQ execution units.
// It grants one completed result per cycle, formats word-sized results (GPR
// sign-extension, FPR NaN-boxing) and drives the single register-file write
// port. It also pulses a one-hot scoreboard release for the written register.

package maverickOne_pkg;
    localparam int XLEN     = 64;
    localparam int NUM_REGS = 64;

    // Result payload from an execution unit. Addresses >= 32 are FPRs.
    typedef struct packed {
        logic [$clog2(NUM_REGS)-1:0] rd;
        logic [XLEN-1:0]             result;
        logic                        word;
    } ext_arb_req_t;
endpackage

module result_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int XLEN     = maverickOne_pkg::XLEN,
    parameter int NUM_REGS = maverickOne_pkg::NUM_REGS,
    localparam int RD_W    = $clog2(NUM_REGS),
    localparam int REQ_W   = RD_W + XLEN + 1,
    localparam int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic                     clk_i,
    input  logic                     arst_ni,
    // Lane i occupies req_i[i*REQ_W +: REQ_W], laid out as {rd, result, word}
    // (the packed ext_arb_req_t layout).
    input  logic [NUM_REQ*REQ_W-1:0] req_i,
    input  logic [NUM_REQ-1:0]       req_valid_i,
    output logic [NUM_REQ-1:0]       req_ready_o,
    output logic                     wr_en_o,
    output logic [RD_W-1:0]          wr_addr_o,
    output logic [XLEN-1:0]          wr_data_o,
    output logic [NUM_REGS-1:0]      unlock_o
);

    // Formats an accepted result for the register file. Word results headed
    // for an FPR are NaN-boxed, and those headed for a GPR are sign-extended.
    function automatic logic [XLEN-1:0] fmt_data(input logic [RD_W-1:0] rd,
                                                 input logic [XLEN-1:0] res,
                                                 input logic            word);
        logic [XLEN-1:0] data;
        if (!word) begin
            data = res;
        end else if (int'(rd) >= 32) begin
            data = {{(XLEN-32){1'b1}}, res[31:0]};
        end else begin
            data = {{(XLEN-32){res[31]}}, res[31:0]};
        end
        return data;
    endfunction

    logic [PTR_W-1:0]    ptr_q, ptr_d;
    logic                wr_en_q, wr_en_d;
    logic [RD_W-1:0]     wr_addr_q, wr_addr_d;
    logic [XLEN-1:0]     wr_data_q, wr_data_d;
    logic [NUM_REGS-1:0] unlock_q, unlock_d;

    logic [NUM_REQ-1:0]  grant;
    logic [PTR_W-1:0]    gnt_idx;
    logic                hs;
    logic [REQ_W-1:0]    lane;
    logic [RD_W-1:0]     sel_rd;
    logic [XLEN-1:0]     sel_result;
    logic                sel_word;

    // Winner search: the first valid lane starting at ptr, wrapping around.
    // A grant is only ever given to a valid lane, so a grant is a handshake.
    always_comb begin
        grant   = '0;
        gnt_idx = '0;
        hs      = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!hs && req_valid_i[(int'(ptr_q) + k) % NUM_REQ]) begin
                hs      = 1'b1;
                gnt_idx = PTR_W'((int'(ptr_q) + k) % NUM_REQ);
            end
        end
        grant[gnt_idx] = hs;
    end

    assign req_ready_o = grant;

    // Extract the winning lane's payload.
    always_comb begin
        lane       = req_i[int'(gnt_idx)*REQ_W +: REQ_W];
        sel_word   = lane[0];
        sel_result = lane[XLEN:1];
        sel_rd     = lane[REQ_W-1 -: RD_W];
    end

    // Next-state logic for the pointer and the registered write port. The
    // x0 destination is consumed but never written or unlocked.
    always_comb begin
        ptr_d     = ptr_q;
        wr_en_d   = 1'b0;
        unlock_d  = '0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        if (hs) begin
            ptr_d     = (int'(gnt_idx) == NUM_REQ - 1) ? '0 : gnt_idx + PTR_W'(1);
            wr_en_d   = (sel_rd != '0);
            wr_addr_d = sel_rd;
            wr_data_d = fmt_data(sel_rd, sel_result, sel_word);
            unlock_d  = (sel_rd != '0) ? (NUM_REGS'(1) << sel_rd) : '0;
        end
    end

    // State registers, cleared asynchronously. A handshake coinciding with
    // reset is dropped.
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            ptr_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            unlock_q  <= '0;
        end else begin
            ptr_q     <= ptr_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            unlock_q  <= unlock_d;
        end
    end

    assign wr_en_o   = wr_en_q;
    assign wr_addr_o = wr_addr_q;
    assign wr_data_o = wr_data_q;
    assign unlock_o  = unlock_q;

endmodule

// File: doc/result_arbiter.md
# result_arbiter

Write-back arbiter at the consumer end of the `ext_arb_req_t` interface. Collects completed results from `NUM_REQ` execution units over independent valid/ready channels and grants one per cycle in round-robin order. Formats word-sized results (sign-extension for GPRs, NaN-boxing for FPRs) and drives the single register-file write port. Pulses a one-hot release of the destination register back to the instruction launcher's scoreboard.

## Interface
- `NUM_REQ`, 4: number of requesting execution units (≥2).
- `XLEN`, `maverickOne_pkg::XLEN` (64): result width.
- `NUM_REGS`, `maverickOne_pkg::NUM_REGS` (64): unified GPR+FPR count; addresses ≥32 are FPRs.
- `clk_i`  in  1  clock; all state updates on rising edge.
- `arst_ni`  in  1  reset, asynchronous, active-low.
- `req_i`  in  NUM_REQ × `ext_arb_req_t`  per-unit payload {rd, result, word}.
- `req_valid_i`  in  NUM_REQ  per-unit request valid.
- `req_ready_o`  out  NUM_REQ  per-unit grant/accept (combinational).
- `wr_en_o`  out  1  register-file write enable (registered).
- `wr_addr_o`  out  $clog2(NUM_REGS)  write address (registered).
- `wr_data_o`  out  XLEN  formatted write data (registered).
- `unlock_o`  out  NUM_REGS  one-hot release of `wr_addr_o` (registered pulse).

## Operation
- Round-robin pointer `ptr` (width $clog2(NUM_REQ)), reset 0. Winner = first index i with `req_valid_i[i]`, searching `ptr, ptr+1, …` modulo `NUM_REQ`.
- `req_ready_o` = one-hot winner vector; all-zero when no valid. Never asserted for an invalid channel. No backpressure from the register file: a valid request is always accepted whenever it wins.
- Handshake completes when `req_valid_i[i] & req_ready_o[i]`. Requesters hold valid and payload stable until accepted; a losing requester stays pending with no penalty.
- On a handshake at index g: `ptr` ← (g+1) mod NUM_REQ. No handshake: `ptr` holds. Wrap from NUM_REQ-1 to 0.
- Data formatting of accepted payload:
  - `word`=0: data = result.
  - `word`=1, rd<32: data = sign-extend result[31:0] to XLEN.
  - `word`=1, rd≥32: data = {32'hFFFF_FFFF, result[31:0]} (NaN-boxing).
- `rd`=0 (x0): handshake completes normally, `ptr` advances, but `wr_en_o`=0 and `unlock_o`=0 in the output cycle (x0 is never locked).
- `rd`≥32: written and unlocked normally (f0 is a real register).
- Output stage: on handshake, register `wr_en_o`=(rd≠0), `wr_addr_o`=rd, `wr_data_o`=formatted data, `unlock_o`=(rd≠0) ? 1<<rd : 0. Without a handshake, `wr_en_o` and `unlock_o` return to 0; `wr_addr_o`/`wr_data_o` hold their last values.
- Reset (any time, including mid-transfer): asynchronously clears `ptr`, `wr_en_o`, `wr_addr_o`, `wr_data_o`, `unlock_o` to 0. A payload handshaken in the cycle reset asserts is dropped. `req_ready_o` stays combinational, so requesters need no reset interlock.

## Timing
- Grant combinational in the same cycle as `req_valid_i`. Handshake at edge N is visible on `wr_*`/`unlock_o` for cycle N+1: 1-cycle latency.
- Throughput is one write per cycle sustained. `wr_en_o` and `unlock_o` are single-cycle pulses per accepted request.
- With K continuously valid requesters, each one is granted at least once every K cycles (starvation-free).
- Reset values: every output 0; `req_ready_o` = 0 while all `req_valid_i` = 0.

## Test plan
- Reset: drive `arst_ni`=0 with random inputs -> `wr_en_o`=0, `wr_addr_o`=0, `wr_data_o`=0, `unlock_o`=0 immediately. First grant after release goes to the lowest valid index.
- GPR word sign-extension: req1 {rd=5, result=64'h0000_0000_8000_0001, word=1} -> `req_ready_o`=4'b0010 same cycle. Next cycle `wr_en_o`=1, `wr_addr_o`=5, `wr_data_o`=64'hFFFF_FFFF_8000_0001, `unlock_o`=1<<5. The cycle after that, `wr_en_o`=0.
- FPR NaN-boxing: req2 {rd=40, result=64'h1234_5678_3F80_0000, word=1} -> `wr_data_o`=64'hFFFF_FFFF_3F80_0000, `unlock_o`=1<<40. Same payload with word=0 -> data unchanged.
- Round-robin: all 4 requesters held valid for 8 cycles -> grant order 0,1,2,3,0,1,2,3, `wr_en_o` high 8 consecutive cycles. Then grant idx1, then only req0 valid -> req0 granted, `ptr`=1.
- x0 discard: req3 {rd=0, result=64'hDEAD, word=0} -> `req_ready_o[3]`=1, next cycle `wr_en_o`=0, `unlock_o`=0, `ptr`=0.
- Reset mid-stream: all requesters valid, assert `arst_ni`=0 while `wr_en_o`=1 -> outputs 0 asynchronously. After release, grants restart at index 0.
